// File: rtl/ptvm_multi_vend_fsm.sv
// Multi-product vending controller: coin credit, priced selection,
// cancel/refund and serial greedy change payout.
module ptvm_multi_vend_fsm #(
    parameter int                          CREDIT_W   = 8,
    parameter int                          NUM_PROD   = 4,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES    = {8'd9, 8'd6, 8'd5, 8'd3},
    parameter int                          MAX_CREDIT = 20
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [2:0]                    coin,
    input  logic [$clog2(NUM_PROD)-1:0]   sel,
    input  logic                          sel_valid,
    input  logic                          cancel,
    output logic                          vend,
    output logic [$clog2(NUM_PROD)-1:0]   vend_id,
    output logic [2:0]                    change_coin,
    output logic [CREDIT_W-1:0]           credit,
    output logic [1:0]                    state,
    output logic                          coin_reject,
    output logic                          no_funds
);

    localparam int SW = $clog2(NUM_PROD);
    localparam int NW = CREDIT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_VEND    = 2'b10,
        S_CHANGE  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_q, vend_d;
    logic [SW-1:0]       vend_id_q, vend_id_d;
    logic [2:0]          change_q, change_d;
    logic                reject_q, reject_d;
    logic                no_funds_q, no_funds_d;

    logic                coin_ok;
    logic [CREDIT_W-1:0] coin_units;
    logic [NW-1:0]       next_w;
    logic                accept;
    logic [CREDIT_W-1:0] cr;
    logic                sel_ok;
    logic [CREDIT_W-1:0] price;

    // Greedy payout: largest coin that still fits the remaining credit.
    function automatic logic [2:0] pay_code(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(5)) begin
            return 3'b101;
        end else if (c >= CREDIT_W'(2)) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    function automatic logic [CREDIT_W-1:0] pay_units(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(5)) begin
            return CREDIT_W'(5);
        end else if (c >= CREDIT_W'(2)) begin
            return CREDIT_W'(2);
        end else begin
            return CREDIT_W'(1);
        end
    endfunction

    always_comb begin
        coin_ok    = 1'b1;
        coin_units = '0;
        unique case (coin)
            3'b000:  coin_units = CREDIT_W'(0);
            3'b001:  coin_units = CREDIT_W'(1);
            3'b010:  coin_units = CREDIT_W'(2);
            3'b011:  coin_units = CREDIT_W'(3);
            3'b100:  coin_units = CREDIT_W'(4);
            3'b101:  coin_units = CREDIT_W'(5);
            default: coin_ok    = 1'b0;
        endcase
    end

    // One extra bit so a coin on top of a near-full credit cannot wrap.
    assign next_w = {1'b0, credit_q} + {1'b0, coin_units};
    assign accept = coin_ok && (next_w <= NW'(MAX_CREDIT));
    assign cr     = accept ? next_w[CREDIT_W-1:0] : credit_q;
    assign sel_ok = (int'(sel) < NUM_PROD);

    always_comb begin
        price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (int'(sel) == i) begin
                price = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        vend_d     = 1'b0;
        vend_id_d  = vend_id_q;
        change_d   = 3'b000;
        reject_d   = 1'b0;
        no_funds_d = 1'b0;
        unique case (state_q)
            S_IDLE, S_COLLECT: begin
                reject_d = !accept;
                credit_d = cr;
                if (cancel) begin
                    if (cr != '0) begin
                        state_d  = S_CHANGE;
                        change_d = pay_code(cr);
                        credit_d = cr - pay_units(cr);
                    end
                end else if (sel_valid && sel_ok && (cr >= price)) begin
                    state_d   = S_VEND;
                    vend_d    = 1'b1;
                    vend_id_d = sel;
                    credit_d  = cr - price;
                end else begin
                    no_funds_d = sel_valid;
                    state_d    = (cr != '0) ? S_COLLECT : S_IDLE;
                end
            end
            S_VEND, S_CHANGE: begin
                reject_d = (coin != 3'b000);
                if (credit_q != '0) begin
                    state_d  = S_CHANGE;
                    change_d = pay_code(credit_q);
                    credit_d = credit_q - pay_units(credit_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            vend_q     <= 1'b0;
            vend_id_q  <= '0;
            change_q   <= 3'b000;
            reject_q   <= 1'b0;
            no_funds_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            vend_q     <= vend_d;
            vend_id_q  <= vend_id_d;
            change_q   <= change_d;
            reject_q   <= reject_d;
            no_funds_q <= no_funds_d;
        end
    end

    assign vend        = vend_q;
    assign vend_id     = vend_id_q;
    assign change_coin = change_q;
    assign credit      = credit_q;
    assign state       = state_q;
    assign coin_reject = reject_q;
    assign no_funds    = no_funds_q;

endmodule

// File: tb/tb_ptvm_multi_vend_fsm.sv
// Bench for ptvm_multi_vend_fsm: directed scenarios then random traffic
// against a credit/payout-queue reference model.
module tb_ptvm_multi_vend_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] coin;
    logic [1:0] sel;
    logic       sel_valid;
    logic       cancel;
    logic       vend;
    logic [1:0] vend_id;
    logic [2:0] change_coin;
    logic [7:0] credit;
    logic [1:0] state;
    logic       coin_reject;
    logic       no_funds;

    ptvm_multi_vend_fsm #(
        .CREDIT_W   (8),
        .NUM_PROD   (4),
        .PRICES     ({8'd9, 8'd6, 8'd5, 8'd3}),
        .MAX_CREDIT (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .coin        (coin),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .cancel      (cancel),
        .vend        (vend),
        .vend_id     (vend_id),
        .change_coin (change_coin),
        .credit      (credit),
        .state       (state),
        .coin_reject (coin_reject),
        .no_funds    (no_funds)
    );

    always #5 clock = ~clock;

    int nchk = 0;
    int nerr = 0;

    int price_tab[4] = '{3, 5, 6, 9};
    int units_tab[8] = '{0, 1, 2, 3, 4, 5, -1, -1};

    int m_state, m_credit, m_vend, m_vid, m_chg, m_rej, m_nf;
    int pay_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_credit = 0; m_vend = 0; m_vid = 0;
        m_chg = 0; m_rej = 0; m_nf = 0;
        pay_q.delete();
    endtask

    task automatic pay_one();
        int u;
        u = pay_q.pop_front();
        m_credit -= u;
        m_chg = u;
        m_state = 3;
    endtask

    task automatic start_payout();
        int c;
        c = m_credit;
        pay_q.delete();
        repeat (c / 5) pay_q.push_back(5);
        repeat ((c % 5) / 2) pay_q.push_back(2);
        if ((c % 5) % 2 == 1) pay_q.push_back(1);
        pay_one();
    endtask

    task automatic model_step(input int c, input int s, input int v, input int k);
        int val;
        m_vend = 0; m_chg = 0; m_rej = 0; m_nf = 0;
        if (m_state == 0 || m_state == 1) begin
            val = units_tab[c];
            if (val < 0 || m_credit + val > 20) m_rej = 1;
            else m_credit += val;
            if (k) begin
                if (m_credit > 0) start_payout();
            end else if (v && m_credit >= price_tab[s]) begin
                m_credit -= price_tab[s];
                m_vend = 1;
                m_vid = s;
                m_state = 2;
            end else begin
                m_nf = v;
                m_state = (m_credit > 0) ? 1 : 0;
            end
        end else begin
            m_rej = (c != 0);
            if (pay_q.size() > 0 || (m_state == 2 && m_credit > 0)) begin
                if (m_state == 2) start_payout();
                else pay_one();
            end else begin
                m_state = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("credit", credit, m_credit);
        chk("vend", vend, m_vend);
        chk("change_coin", change_coin, m_chg);
        chk("coin_reject", coin_reject, m_rej);
        chk("no_funds", no_funds, m_nf);
        if (m_vend != 0) chk("vend_id", vend_id, m_vid);
    endtask

    task automatic cyc(input int c, input int s, input int v, input int k);
        coin = 3'(c); sel = 2'(s); sel_valid = v[0]; cancel = k[0];
        model_step(c, s, v, k);
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clock);
        reset = 1'b0;
        cyc(0, 0, 0, 0);
    endtask

    initial begin
        coin = 3'b000; sel = 2'b00; sel_valid = 1'b0; cancel = 1'b0;
        reset = 1'b1;
        do_reset();

        // single quarter buys product 1 exactly
        cyc(5, 0, 0, 0);
        cyc(0, 1, 1, 0);
        chk("t1_vend", vend, 1);
        chk("t1_credit", credit, 0);
        cyc(0, 0, 0, 0);
        chk("t1_idle", state, 0);

        // overpay then two change coins
        cyc(5, 0, 0, 0);
        cyc(5, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("t2_credit", credit, 7);
        cyc(0, 0, 0, 0);
        chk("t2_chg1", change_coin, 3'b101);
        cyc(0, 0, 0, 0);
        chk("t2_chg2", change_coin, 3'b010);
        cyc(0, 0, 0, 0);
        chk("t2_idle", state, 0);

        // insufficient funds then cancel
        cyc(2, 0, 0, 0);
        cyc(0, 3, 1, 0);
        chk("t3_nf", no_funds, 1);
        chk("t3_credit", credit, 2);
        cyc(0, 0, 0, 1);
        chk("t3_refund", change_coin, 3'b010);
        cyc(0, 0, 0, 0);

        // credit ceiling and invalid coin
        repeat (4) cyc(5, 0, 0, 0);
        chk("t4_full", credit, 20);
        cyc(5, 0, 0, 0);
        chk("t4_rej", coin_reject, 1);
        cyc(0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(6, 0, 0, 0);
        chk("t4_inv", coin_reject, 1);
        chk("t4_idle", state, 0);

        // coin during VEND, then async reset mid-payout
        cyc(5, 0, 0, 0);
        cyc(5, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("t5_rej", coin_reject, 1);
        chk("t5_chg", change_coin, 3'b101);
        #2;
        do_reset();

        // coin and selection honoured together; cancel beats selection
        cyc(2, 0, 0, 0);
        cyc(2, 0, 0, 0);
        cyc(1, 1, 1, 0);
        chk("t6_vend", vend, 1);
        chk("t6_credit", credit, 0);
        cyc(0, 0, 0, 0);
        cyc(5, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 1);
        chk("t6_novend", vend, 0);
        chk("t6_r1", change_coin, 3'b101);
        cyc(0, 0, 0, 0);
        chk("t6_r2", change_coin, 3'b001);
        cyc(0, 0, 0, 0);

        for (int n = 0; n < 4000; n++) begin
            int c, s, v, k;
            c = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(0, 7));
            s = int'($urandom_range(0, 3));
            v = ($urandom_range(0, 4) == 0) ? 1 : 0;
            k = ($urandom_range(0, 11) == 0) ? 1 : 0;
            if ($urandom_range(0, 599) == 0) begin
                #2;
                do_reset();
            end else begin
                cyc(c, s, v, k);
            end
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
